lc3_mem_arbiter: RTL and testbench

- Sequences the shared LC-3 main memory (MEM_EN/RW/MAR_OUT/MDR_OUT in; OUT/R back) between two requesters: instruction fetch (IF) and data load/store (D).
- Runs the memory's ready handshake, captures read data, and returns a one-cycle acknowledge to the granted requester.
- Flags out-of-range addresses without touching memory.
- Sits between the control FSM/datapath and the memory block.

---
 rtl/lc3_mem_arbiter_if.sv | 31 +++
 rtl/lc3_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC-3 requesters (fetch, data), the arbiter and main memory.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface lc3_mem_arbiter_if;
  logic        IF_REQ;
  logic [15:0] IF_ADDR;
  logic [15:0] IF_DATA;
  logic        IF_ACK;
  logic        D_REQ;
  logic        D_WE;
  logic [15:0] D_ADDR;
  logic [15:0] D_WDATA;
  logic [15:0] D_RDATA;
  logic        D_ACK;
  logic        ERR;
  logic        MEM_EN;
  logic        RW;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic [15:0] MEM_OUT;
  logic        R;

  modport slave (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_OUT, R,
    output IF_DATA, IF_ACK, D_RDATA, D_ACK, ERR, MEM_EN, RW, MAR_OUT, MDR_OUT
  );

  modport master (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_OUT, R,
    input  IF_DATA, IF_ACK, D_RDATA, D_ACK, ERR, MEM_EN, RW, MAR_OUT, MDR_OUT
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing LC-3 main memory between instruction fetch and data access.
// Define MEM_TIMEOUT_EN to abort accesses whose ready never arrives.
module lc3_mem_arbiter #(
  parameter int unsigned MEM_DEPTH = 28800
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  lc3_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, FAIL} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;     // owner of the current transaction, 1 = data port
  logic        last_q, last_d;   // last granted port, 1 = data port
  logic        mem_en_q, mem_en_d;
  logic        rw_q, rw_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] if_data_q, if_data_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;

  logic        start;
  logic        pick_data;
  logic [15:0] req_addr;
  logic        in_range;
  logic        timeout_hit;

  assign start     = !bus.R && (bus.IF_REQ || bus.D_REQ);
  assign pick_data = bus.D_REQ && (!bus.IF_REQ || !last_q);
  assign req_addr  = pick_data ? bus.D_ADDR : bus.IF_ADDR;
  assign in_range  = 32'(req_addr) < MEM_DEPTH;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == ACCESS) && !bus.R && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = ((state_q == ACCESS) && !bus.R && !timeout_hit) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      mem_en_q  <= 1'b0;
      rw_q      <= 1'b0;
      mar_q     <= 16'h0000;
      mdr_q     <= 16'h0000;
      if_data_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      mem_en_q  <= mem_en_d;
      rw_q      <= rw_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = in_range ? ACCESS : FAIL;
      ACCESS:   if (bus.R) state_d = COMPLETE;
                else if (timeout_hit) state_d = FAIL;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle early so ACK/ERR appear as registers in COMPLETE/FAIL.
  always_comb begin
    mem_en_d  = mem_en_q;
    rw_d      = rw_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    if_ack_d  = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    gnt_d     = gnt_q;
    last_d    = last_q;
    case (state_q)
      IDLE: if (start) begin
        gnt_d    = pick_data;
        last_d   = pick_data;
        mar_d    = req_addr;
        rw_d     = pick_data && bus.D_WE;
        mdr_d    = pick_data ? bus.D_WDATA : 16'h0000;
        mem_en_d = in_range;
        if (!in_range) begin
          if_ack_d = !pick_data;
          d_ack_d  = pick_data;
          err_d    = 1'b1;
          if (!pick_data)      if_data_d = 16'h0000;
          else if (!bus.D_WE)  d_rdata_d = 16'h0000;
        end
      end
      ACCESS: if (bus.R || timeout_hit) begin
        mem_en_d = 1'b0;
        if_ack_d = !gnt_q;
        d_ack_d  = gnt_q;
        err_d    = !bus.R;
        if (!rw_q) begin
          if (gnt_q) d_rdata_d = bus.R ? bus.MEM_OUT : 16'h0000;
          else       if_data_d = bus.R ? bus.MEM_OUT : 16'h0000;
        end
      end
      default: ;
    endcase
  end

  assign bus.MEM_EN  = mem_en_q;
  assign bus.RW      = rw_q;
  assign bus.MAR_OUT = mar_q;
  assign bus.MDR_OUT = mdr_q;
  assign bus.IF_DATA = if_data_q;
  assign bus.D_RDATA = d_rdata_q;
  assign bus.IF_ACK  = if_ack_q;
  assign bus.D_ACK   = d_ack_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter with a registered-ready memory model.
module tb_lc3_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_mem_arbiter_if bus();
  lc3_mem_arbiter dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

  // Memory model: ready follows enable by one edge unless stalled.
  logic [15:0] mem [0:65535];
  logic        stall;
  logic        pl_we;
  logic [15:0] pl_addr, pl_data;

  always @(posedge clk or posedge rst) begin
    if (rst) bus.R <= 1'b0;
    else     bus.R <= bus.MEM_EN && !stall;
  end
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.MEM_EN && bus.RW) mem[bus.MAR_OUT] <= bus.MDR_OUT;
  end
  assign bus.MEM_OUT = mem[bus.MAR_OUT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct { bit port; logic [15:0] data; bit err; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] if_m, d_m;
  int          last_ack_cyc;
  bit          last_ok = 1'b0;

  task automatic push_exp(input bit port, input bit we, input logic [15:0] data, input bit err);
    exp_t e;
    e.port = port;
    e.err  = err;
    if (we) e.data = port ? d_m : if_m;
    else begin
      e.data = data;
      if (port) d_m = data; else if_m = data;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) last_ok = 1'b0;
    else begin
      if (bus.MEM_EN) en_cycles++;
      if (bus.ERR) check_eq("err_needs_ack", bus.IF_ACK || bus.D_ACK, 1);
      if (bus.IF_ACK || bus.D_ACK) begin
        check_eq("ack_exclusive", bus.IF_ACK && bus.D_ACK, 0);
        $display("ack port=%s data=0x%04h err=%0d cyc=%0d", bus.D_ACK ? "D" : "IF",
                 bus.D_ACK ? bus.D_RDATA : bus.IF_DATA, bus.ERR, cyc);
        check_eq("ack_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("ack_port", bus.D_ACK, mon_e.port);
          check_eq("ack_data", mon_e.port ? bus.D_RDATA : bus.IF_DATA, mon_e.data);
          check_eq("ack_err", bus.ERR, mon_e.err);
        end
        if (!bus.ERR && last_ok) check_eq("ack_spacing_ge4", (cyc - last_ack_cyc) >= 4, 1);
        last_ack_cyc = cyc;
        last_ok      = !bus.ERR;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if_m = 16'h0000;
    d_m  = 16'h0000;
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic do_req(input bit port, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_data, input bit exp_err, input int exp_lat, input int exp_en);
    int c0;
    bit got;
    repeat (2) @(negedge clk);
    push_exp(port, we, exp_data, exp_err);
    en_cycles = 0;
    if (port) begin
      bus.D_WE = we; bus.D_ADDR = addr; bus.D_WDATA = wdata; bus.D_REQ = 1'b1;
    end else begin
      bus.IF_ADDR = addr; bus.IF_REQ = 1'b1;
    end
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.D_ACK : bus.IF_ACK) got = 1'b1;
    end
    check_eq("ack_seen", got, 1);
    bus.IF_REQ = 1'b0;
    bus.D_REQ  = 1'b0;
    if (got) check_eq("ack_latency", cyc - c0, exp_lat);
    #1;
    check_eq("mem_en_cycles", en_cycles, exp_en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst = 1'b1;
    stall = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.IF_REQ = 1'b0; bus.IF_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;
    if_m = '0; d_m = '0;
    preload(16'h3000, 16'h1234);
    #1;
    check_eq("rst_mem_en", bus.MEM_EN, 0);
    check_eq("rst_rw", bus.RW, 0);
    check_eq("rst_if_ack", bus.IF_ACK, 0);
    check_eq("rst_d_ack", bus.D_ACK, 0);
    check_eq("rst_err", bus.ERR, 0);
    check_eq("rst_mar", bus.MAR_OUT, 16'h0000);
    check_eq("rst_mdr", bus.MDR_OUT, 16'h0000);
    check_eq("rst_if_data", bus.IF_DATA, 16'h0000);
    check_eq("rst_d_rdata", bus.D_RDATA, 16'h0000);
    do_reset();

    do_req(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 3, 2);
    do_req(1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b0, 3, 2);
    do_req(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1'b0, 3, 2);
    do_req(1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1, 0);
    do_req(1'b0, 1'b0, 16'h70FF, 16'h0000, 16'h0000, 1'b1, 1, 0);
    do_req(1'b1, 1'b1, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 1, 0);

    // Both requesters held high from reset: expect strict alternation starting with IF.
    rst = 1'b1;
    bus.IF_ADDR = 16'h3000; bus.IF_REQ = 1'b1;
    bus.D_ADDR = 16'h0100; bus.D_WE = 1'b0; bus.D_REQ = 1'b1;
    repeat (2) @(negedge clk);
    if_m = '0; d_m = '0; sb.delete();
    push_exp(1'b0, 1'b0, 16'h1234, 1'b0);
    push_exp(1'b1, 1'b0, 16'hBEEF, 1'b0);
    push_exp(1'b0, 1'b0, 16'h1234, 1'b0);
    push_exp(1'b1, 1'b0, 16'hBEEF, 1'b0);
    rst  = 1'b0;
    acks = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (bus.IF_ACK || bus.D_ACK) acks++;
    end
    bus.IF_REQ = 1'b0; bus.D_REQ = 1'b0;
    check_eq("contention_acks", acks, 4);
    repeat (6) @(negedge clk);
    check_eq("contention_sb_empty", sb.size(), 0);

    // Reset in the middle of an access drops MEM_EN without a clock edge.
    repeat (2) @(negedge clk);
    bus.IF_ADDR = 16'h3000; bus.IF_REQ = 1'b1;
    @(negedge clk);
    check_eq("mid_mem_en_before", bus.MEM_EN, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_mem_en_async", bus.MEM_EN, 0);
    check_eq("mid_no_ack", bus.IF_ACK, 0);
    repeat (3) @(negedge clk);
    bus.IF_REQ = 1'b0;
    if_m = '0; d_m = '0; sb.delete();
    rst = 1'b0;
    do_req(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 3, 2);

    stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
    do_req(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b1, 16, 15);
    stall = 1'b0;
`else
    repeat (2) @(negedge clk);
    bus.IF_ADDR = 16'h3000; bus.IF_REQ = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("stall_mem_en_held", bus.MEM_EN, 1);
    check_eq("stall_no_ack", bus.IF_ACK, 0);
    bus.IF_REQ = 1'b0;
    stall = 1'b0;
    do_reset();
`endif
    do_req(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1'b0, 3, 2);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
